mdu: RTL
========

# mdu

Iterative-latency multiply/divide unit for the MIPS EX stage, alongside the ALU and driven by the same A/B operand buses. It executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers. It asserts Busy for a fixed multi-cycle latency so the hazard unit can stall mfhi, mflo and further MD instructions.

## Interface
Parameters:
- MULT_CYCLES, default 5: Busy duration for mult and multu.
- DIV_CYCLES, default 10: Busy duration for div and divu.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- A  in  32  operand rs; dividend or multiplicand; also the mthi/mtlo source.
- B  in  32  operand rt; divisor or multiplier.
- Start  in  1  one-cycle request qualifying MDOp.
- MDOp  in  3  operation code:
  - 000 none
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 reserved (no-op)
- HI  out  32  HI register.
- LO  out  32  LO register.
- Busy  out  1  a mult or div is in flight.

## Operation
- State:
  - HI, LO (32 bits each)
  - staging hi_n and lo_n (32 bits each)
  - wr_en flag
  - down-counter cnt (4 bits)
- Busy equals (cnt != 0).
- Reset (reset==0): HI=0, LO=0, cnt=0, Busy=0, staging=0, wr_en=0. Any in-flight operation is discarded.
- Accept condition: Start=1 and Busy=0. Start while Busy=1 is ignored entirely, including for mthi/mtlo. The hazard unit guarantees this does not occur.
- mult: {hi_n,lo_n} = $signed(A) * $signed(B), full 64 bits. cnt = MULT_CYCLES. wr_en = 1.
- multu: same as mult, with unsigned operands.
- div: lo_n = signed quotient, truncated toward zero; hi_n = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo_n=0x80000000, hi_n=0.
  - cnt = DIV_CYCLES.
- divu: unsigned quotient and remainder; cnt = DIV_CYCLES.
- Divide by zero (B==0): Busy runs the full DIV_CYCLES, but wr_en=0, so HI and LO stay unchanged.
- Operands are sampled only on the accept edge. A and B may change afterward.
- mthi: HI <= A on the accept edge. cnt stays 0 and Busy never rises.
- mtlo: LO <= A on the accept edge, same as mthi.
- Counting: each edge with cnt>1 decrements cnt.
  - On the edge with cnt==1: cnt <= 0, and if wr_en then HI <= hi_n and LO <= lo_n.
- HI and LO never change while Busy=1.
- MDOp none or reserved with Start=1: no effect.

## Timing
- Accept at edge E0.
- Busy is high from just after E0 until just after E0+N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles.
- HI and LO take their new values at edge E0+N, the same edge at which Busy falls.
- Back-to-back: a new Start is accepted in the first cycle Busy reads 0. This gives zero bubble after completion.
- mthi and mtlo have 1-edge latency. A read in the next cycle sees the new value.
- Reset mid-operation: asynchronous clear. No HI/LO write ever occurs for the aborted operation.
- All outputs come directly from registers. There is no combinational path from inputs to outputs.

## Structure
- Package md_pkg holds:
  - MDOp code localparams (MD_NONE … MD_MTLO)
  - MULT_CYCLES and DIV_CYCLES defaults
- Sub-module mdu_calc: purely combinational. Inputs A, B and MDOp; outputs hi_n, lo_n and div_by_zero. It isolates signed/unsigned arithmetic from the control logic in mdu.

## Test plan
- Reset, then mult with A=0xFFFFFFFF, B=2:
  - Busy is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with A=0xFFFFFFF9 (-7), B=2:
  - Busy is high for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with A=7, B=0 afterward: Busy is high for 10 cycles and HI/LO are unchanged.
- mthi with A=0x12345678, then mtlo with A=0x9ABCDEF0 on consecutive cycles:
  - HI and LO update one edge after each.
  - Busy stays 0 throughout.
- Start a div, then pulse Start with mtlo at cycle 3 and mult at cycle 4: both are ignored. Only the div result lands, at cycle 10.
- Start a mult, then assert reset at cycle 2: Busy=0, HI=0 and LO=0 immediately, with no later writeback. A mult issued right after reset release completes normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared opcodes and latency defaults for the multiply/divide unit.
package md_pkg;
  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [2:0] MD_RSVD  = 3'b111;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;
endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/div datapath: produces the staged HI/LO result
// for the opcode presented, plus a divide-by-zero flag.
module mdu_calc
  import md_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div_by_zero
);

  logic        sgn;
  logic [63:0] pa;
  logic [63:0] pb;
  logic [63:0] prod;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    sgn  = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    pa   = {{32{sgn & A[31]}}, A};
    pb   = {{32{sgn & B[31]}}, B};
    prod = pa * pb;
    // Magnitude division avoids the INT_MIN / -1 overflow corner.
    ma   = (sgn & A[31]) ? -A : A;
    mb   = (sgn & B[31]) ? -B : B;
    div_by_zero = (B == 32'd0);
    q = '0;
    r = '0;
    if (!div_by_zero) begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn & (A[31] ^ B[31])) q = -q;
    if (sgn & A[31]) r = -r;
    unique case (MDOp)
      MD_DIV, MD_DIVU: {hi_n, lo_n} = {r, q};
      default:         {hi_n, lo_n} = prod;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// MIPS EX-stage multiply/divide unit: fixed-latency Busy window,
// architectural HI/LO written when the window closes.
module mdu
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_n_q, hi_n_d;
  logic [31:0]      lo_n_q, lo_n_d;
  logic             wr_en_q, wr_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [31:0] c_hi;
  logic [31:0] c_lo;
  logic        c_dbz;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;

  mdu_calc u_calc (
    .A           (A),
    .B           (B),
    .MDOp        (MDOp),
    .hi_n        (c_hi),
    .lo_n        (c_lo),
    .div_by_zero (c_dbz)
  );

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    wr_en_d = wr_en_q;
    cnt_d   = cnt_q;
    accept  = Start & ~busy_q;
    is_mul  = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    is_div  = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
    is_mthi = (MDOp == MD_MTHI);
    is_mtlo = (MDOp == MD_MTLO);
    if (accept) begin
      unique case (1'b1)
        is_mul: begin
          hi_n_d  = c_hi;
          lo_n_d  = c_lo;
          wr_en_d = 1'b1;
          cnt_d   = CNT_W'(MULT_CYCLES);
        end
        is_div: begin
          hi_n_d  = c_hi;
          lo_n_d  = c_lo;
          wr_en_d = ~c_dbz;
          cnt_d   = CNT_W'(DIV_CYCLES);
        end
        is_mthi: hi_d = A;
        is_mtlo: lo_d = A;
        default: ;
      endcase
    end else if (cnt_q == CNT_W'(1)) begin
      cnt_d   = '0;
      wr_en_d = 1'b0;
      if (wr_en_q) begin
        hi_d = hi_n_q;
        lo_d = lo_n_q;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      wr_en_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      wr_en_q <= wr_en_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = busy_q;

endmodule
